// File: rtl/ksa_addsub_pipe.sv
// ksa_addsub_pipe: pipelined Kogge-Stone adder/subtractor with valid/ready
// handshakes on both sides.
//   - Subtraction is formed as a + ~b + 1 (b inverted, carry-in = sub).
//   - S0 captures the operands, S1..S_LEVELS are the prefix levels, and a
//     final stage registers sum/cout.
//   - The whole pipe advances together when the output is empty or being
//     popped.
// Optional feature macro: KSA_ADDSUB_OVF_EN adds the signed-overflow
// output ovf_o and its sign pipeline.
module ksa_addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
`ifdef KSA_ADDSUB_OVF_EN
  output logic             ovf_o,
`endif
  output logic             cout_o
);

  // Index 0 is S0 (operand capture); index k is prefix level k.
  logic [LEVELS:0]  r_v;
  logic [LEVELS:0]  r_cin;
  logic [WIDTH-1:0] r_g  [0:LEVELS];
  logic [WIDTH-1:0] r_p  [0:LEVELS];
  logic [WIDTH-1:0] r_p0 [0:LEVELS];

  logic [WIDTH-1:0] w_g_nxt [0:LEVELS];
  logic [WIDTH-1:0] w_p_nxt [0:LEVELS];
  logic [WIDTH-1:0] w_src_g;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_adv;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

`ifdef KSA_ADDSUB_OVF_EN
  // Operand sign bits travel alongside the data for the overflow decision.
  logic [LEVELS:0]  r_a_msb;
  logic [LEVELS:0]  r_bx_msb;
  logic             w_ovf;
  logic             r_ovf;
`endif

  assign w_adv       = !r_out_valid || out_ready_i;
  assign in_ready_o  = w_adv;
  assign out_valid_o = r_out_valid;
  assign sum_o       = r_sum;
  assign cout_o      = r_cout;
  assign w_bx        = b_i ^ {WIDTH{sub_i}};

  // Generate/propagate for S0 and the prefix combine for every level.
  always_comb begin
    w_src_g = '0;
    for (int k = 0; k <= LEVELS; k++) begin
      w_g_nxt[k] = '0;
      w_p_nxt[k] = '0;
    end
    w_g_nxt[0] = a_i & w_bx;
    w_p_nxt[0] = a_i ^ w_bx;
    for (int k = 1; k <= LEVELS; k++) begin
      // Carry-in is folded into bit 0 generate just before level 1.
      if (k == 1) begin
        w_src_g    = r_g[0];
        w_src_g[0] = r_g[0][0] | (r_p[0][0] & r_cin[0]);
      end else begin
        w_src_g = r_g[k-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (k - 1))) begin
          w_g_nxt[k][i] = w_src_g[i] | (r_p[k-1][i] & w_src_g[i - (1 << (k - 1))]);
          w_p_nxt[k][i] = r_p[k-1][i] & r_p[k-1][i - (1 << (k - 1))];
        end else begin
          w_g_nxt[k][i] = w_src_g[i];
          w_p_nxt[k][i] = r_p[k-1][i];
        end
      end
    end
  end

  // Final sum: bit i uses the group carry out of bit i-1 (cin for bit 0).
  assign w_sum  = r_p0[LEVELS] ^ {r_g[LEVELS][WIDTH-2:0], r_cin[LEVELS]};
  assign w_cout = r_g[LEVELS][WIDTH-1];

`ifdef KSA_ADDSUB_OVF_EN
  // Signed overflow: same-sign operands producing a result of the other sign.
  assign w_ovf = (r_a_msb[LEVELS] == r_bx_msb[LEVELS]) &&
                 (w_sum[WIDTH-1] != r_a_msb[LEVELS]);
`endif

  // Pipeline stage registers: all stages shift together on advance.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_v   <= '0;
      r_cin <= '0;
      for (int k = 0; k <= LEVELS; k++) begin
        r_g[k]  <= '0;
        r_p[k]  <= '0;
        r_p0[k] <= '0;
      end
    end else if (w_adv) begin
      r_v   <= {r_v[LEVELS-1:0], in_valid_i};
      r_cin <= {r_cin[LEVELS-1:0], sub_i};
      for (int k = 0; k <= LEVELS; k++) begin
        r_g[k] <= w_g_nxt[k];
        r_p[k] <= w_p_nxt[k];
      end
      r_p0[0] <= w_p_nxt[0];
      for (int k = 1; k <= LEVELS; k++) begin
        r_p0[k] <= r_p0[k-1];
      end
    end
  end

  // Output register: data only updates when a valid result moves in.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_v[LEVELS];
      if (r_v[LEVELS]) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
      end
    end
  end

`ifdef KSA_ADDSUB_OVF_EN
  assign ovf_o = r_ovf;

  // Sign pipeline and registered overflow flag.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_a_msb  <= '0;
      r_bx_msb <= '0;
      r_ovf    <= 1'b0;
    end else if (w_adv) begin
      r_a_msb  <= {r_a_msb[LEVELS-1:0], a_i[WIDTH-1]};
      r_bx_msb <= {r_bx_msb[LEVELS-1:0], w_bx[WIDTH-1]};
      if (r_v[LEVELS]) begin
        r_ovf <= w_ovf;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ksa_addsub_pipe.sv
// Directed, table-driven bench for ksa_addsub_pipe (WIDTH=16).
module tb_ksa_addsub_pipe;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl [0:31];

  ksa_addsub_pipe #(.WIDTH(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .sub_i       (sub),
    .a_i         (a),
    .b_i         (b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
`ifdef KSA_ADDSUB_OVF_EN
    .ovf_o       (ovf),
`endif
    .cout_o      (cout)
  );

`ifndef KSA_ADDSUB_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [15:0] va, input logic [15:0] vb,
                              input logic [15:0] es, input logic ec, input logic eo);
    vec_t v;
    v.sub = s; v.a = va; v.b = vb; v.exp_sum = es; v.exp_cout = ec; v.exp_ovf = eo;
    return v;
  endfunction

  // Streams tbl[base +: n] with optional 4-style backpressure after the first
  // result appears. Entered and left at posedge+1.
  task automatic stream(input int base, input int n, input int stall_len);
    int sent, got, cyc, acc0, first_pop, last_pop, stall_left;
    bit seen, acc, pop;
    sent = 0; got = 0; cyc = 0; acc0 = 0; first_pop = 0; last_pop = 0;
    stall_left = stall_len; seen = 1'b0;
    while (got < n && cyc < 200) begin
      out_ready = !(seen && stall_left > 0);
      if (seen && stall_left > 0) stall_left--;
      in_valid = (sent < n);
      if (sent < n) begin
        sub = tbl[base+sent].sub; a = tbl[base+sent].a; b = tbl[base+sent].b;
      end else begin
        sub = 1'b0; a = 16'h0000; b = 16'h0000;
      end
      #1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (acc && sent == 0) acc0 = cyc;
      if (out_valid && !seen) begin
        seen = 1'b1;
        chk("latency", cyc - acc0, 6);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_hold_sum", {16'd0, sum}, {16'd0, tbl[base+got].exp_sum});
      end
      if (pop) begin
        chk($sformatf("sum[%0d]", base+got), {16'd0, sum}, {16'd0, tbl[base+got].exp_sum});
        chk($sformatf("cout[%0d]", base+got), {31'd0, cout}, {31'd0, tbl[base+got].exp_cout});
`ifdef KSA_ADDSUB_OVF_EN
        chk($sformatf("ovf[%0d]", base+got), {31'd0, ovf}, {31'd0, tbl[base+got].exp_ovf});
`endif
        if (got == 0) first_pop = cyc;
        last_pop = cyc;
        got++;
      end
      if (acc) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (got < n) chk("stream_timeout", got, n);
    if (stall_len == 0) chk("back_to_back", last_pop - first_pop, n - 1);
  endtask

  initial begin
    int stray;
    // Misc vectors (base 0)
    tbl[0]  = mk(1'b1, 16'h1234, 16'h0034, 16'h1200, 1'b1, 1'b0);
    tbl[1]  = mk(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
    tbl[7]  = mk(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    tbl[8]  = mk(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    tbl[11] = mk(1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1);
    // Stream: a=i*0x1111, b=0x0101, odd i subtract (base 12)
    tbl[12] = mk(1'b0, 16'h0000, 16'h0101, 16'h0101, 1'b0, 1'b0);
    tbl[13] = mk(1'b1, 16'h1111, 16'h0101, 16'h1010, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 16'h2222, 16'h0101, 16'h2323, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 16'h3333, 16'h0101, 16'h3232, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 16'h4444, 16'h0101, 16'h4545, 1'b0, 1'b0);
    tbl[17] = mk(1'b1, 16'h5555, 16'h0101, 16'h5454, 1'b1, 1'b0);
    tbl[18] = mk(1'b0, 16'h6666, 16'h0101, 16'h6767, 1'b0, 1'b0);
    tbl[19] = mk(1'b1, 16'h7777, 16'h0101, 16'h7676, 1'b1, 1'b0);
    // Post-reset op (base 20)
    tbl[20] = mk(1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sub = 1'b0; a = 16'h0000; b = 16'h0000;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Each misc vector alone, so every result sees an empty pipe
    for (int i = 0; i < 12; i++) stream(i, 1, 0);
    // Back-to-back stream, then the same stream with 4 cycles of backpressure
    stream(12, 8, 0);
    stream(12, 8, 4);

    // Reset with operations in flight and a result waiting at the output
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; sub = 1'b0; a = 16'h0010 + 16'(i); b = 16'h0001;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_sum", {16'd0, sum}, 32'h0011);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_sum", {16'd0, sum}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1; out_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    chk("no_stale_after_reset", stray, 0);
    stream(20, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ksa_addsub_pipe.md
Name: ksa_addsub_pipe

Overview:
- Pipelined, registered Kogge-Stone adder/subtractor. It is the subtract-capable, clocked counterpart to the combinational 16-bit KS adder on the user IO path.
- Each operation computes either a+b or a−b. Subtraction is formed as a + ~b + 1.
- Every prefix level has its own register stage, and the block uses valid/ready handshakes on both sides.
- Sits between the Wishbone/LA operand registers and the result capture logic in the user project.

Parameters:
- WIDTH, 16, operand width; must be a power of two, 8..32.
- LEVELS, $clog2(WIDTH), number of prefix levels (derived; do not override).

Ports:
- wb_clk_i  input  1  clock, rising edge.
- wb_rst_n_i  input  1  asynchronous active-low reset.
- in_valid_i  input  1  operand beat valid.
- in_ready_o  output  1  block can accept an operand beat.
- sub_i  input  1  0 = a+b, 1 = a−b.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts the result.
- sum_o  output  WIDTH  result, modulo 2^WIDTH.
- cout_o  output  1  carry out of the MSB. For subtract: 1 = no borrow (a ≥ b unsigned).
- ovf_o  output  1  signed overflow; present only with KSA_ADDSUB_OVF_EN (see Optional Feature).

Behaviour:
- Reset (wb_rst_n_i low, asynchronous assert, synchronous-to-clock deassert use):
  - All stage valid bits are 0 and all datapath registers are 0.
  - Outputs: out_valid_o=0, sum_o=0, cout_o=0, ovf_o=0.
  - in_ready_o=1 from the first cycle after reset is released.
- Pipeline stages (one register each; stage valid bit travels with the data):
  - S0: capture a, bx=b^{WIDTH{sub}}, cin=sub. Form g=a&bx and p=a^bx. Keep p0 (the original propagate) for the sum.
  - S1..S_LEVELS: prefix level k combines with distance 2^(k-1), using G=Gi|(Pi&Gprev) and P=Pi&Pprev. Bits below the distance pass through unchanged.
  - cin is folded in at bit 0 as g0'=g0|(p0&cin) before S1.
  - Final stage: sum[0]=p0[0]^cin and sum[i]=p0[i]^G[i-1]; cout=G[WIDTH-1]. All are registered to the outputs.
- Latency: LEVELS+2 cycles from in_valid_i&&in_ready_o to out_valid_o when there is no stall. WIDTH=16 gives 6 cycles.
- Throughput: one operation per cycle.
- Advance condition: adv = !out_valid_o || out_ready_i.
  - All stages shift together when adv=1 and all hold when adv=0.
  - in_ready_o = adv (combinational from out_ready_i and out_valid_o only; never from in_valid_i).
  - Bubbles are not squeezed: an empty stage still takes one cycle to pass.
- Output hold: while out_valid_o=1 and out_ready_i=0, sum_o, cout_o and ovf_o hold stable.
- When out_valid_o=0 the output data registers keep their last value; it must not be consumed.
- Simultaneous events:
  - Input accept and output pop in the same cycle is legal; occupancy is unchanged.
  - An input offered while stalled is not accepted, and its operands are not sampled.
- Boundary cases:
  - 0−0 gives sum=0, cout=1.
  - x−x gives sum=0, cout=1.
  - 0+0 gives sum=0, cout=0.
- Reset mid-operation: every in-flight operation is discarded. No result emerges after reset release.
- No X propagation: stage data registers load only when adv=1. The stage valid bit loads on every adv.

Optional Feature:
- Macro: KSA_ADDSUB_OVF_EN.
- Defined:
  - ovf_o is a port, registered alongside sum_o.
  - ovf = (a[MSB]==bx[MSB]) && (sum[MSB]!=a[MSB]), with a and bx taken from S0 and carried down the pipe.
- Undefined:
  - ovf_o port is absent, along with its sign pipeline registers.
  - All other behaviour and latency are identical.

Test Plan:
1. Reset, then sub=1, a=0x1234, b=0x0034 -> 6 cycles later out_valid_o=1, sum_o=0x1200, cout_o=1.
2. sub=1, a=0x0000, b=0x0001 -> sum_o=0xFFFF, cout_o=0. Then sub=0, a=0xFFFF, b=0x0001 -> sum_o=0x0000, cout_o=1.
3. Stream 8 back-to-back ops: a=i*0x1111, b=0x0101, sub alternating, with out_ready_i=1. Expect results on 8 consecutive cycles starting at cycle 6, in order, matching the reference model.
4. Backpressure: during test 3, hold out_ready_i=0 for 4 cycles once out_valid_o=1. Expect in_ready_o=0, outputs stable, no loss or duplication; ordering resumes when out_ready_i returns to 1.
5. Reset mid-stream: assert wb_rst_n_i low with 3 ops in flight. Expect out_valid_o=0 immediately (asynchronous) and no stale result after release. A new op 0x00FF+0x0001 returns 0x0100, cout=0.
6. With KSA_ADDSUB_OVF_EN:
   - sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf_o=1.
   - sub=0, a=0x7FFF, b=0x0001 -> sum=0x8000, ovf_o=1.
   - sub=0, a=0x0001, b=0x0001 -> ovf_o=0.
   - Without the macro, the same vectors give identical sum/cout.
